fb_scaler_copy: RTL and testbench

Parametrised successor to the CHIP-8 display copier. It streams the display area from main RAM into the framebuffer RAM, one byte per cycle. It optionally applies 2x pixel doubling (horizontal bit duplication plus vertical row repeat), or clears the destination area without reading main RAM. It sits between main RAM (read port) and framebuffer RAM (write port), and is triggered by the CPU/timing logic once per frame.

---
 rtl/fb_scaler_copy.sv | 180 ++++++++++++++++++
 tb/tb_fb_scaler_copy.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scaler_copy.sv
// fb_scaler_copy: streams the display area from main RAM into framebuffer RAM,
// one byte per cycle, with optional 2x pixel doubling or a clear-only mode.
module fb_scaler_copy #(
    parameter int unsigned SRC_BASE = 'h100,
    parameter int unsigned SRC_BPR  = 8,
    parameter int unsigned SRC_ROWS = 32,
    parameter int unsigned SCALE    = 1,
    parameter int unsigned FB_PITCH = 32,
    parameter int unsigned FB_AW    = 10,
    parameter int unsigned RAM_AW   = 12,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_signal,
    input  logic              clear_mode,
    output logic              busy,
    output logic              finished_signal,
    output logic [RAM_AW-1:0] main_ram_read_address,
    input  logic [7:0]        main_ram_out,
    output logic [FB_AW-1:0]  fb_write_address,
    output logic              fb_write_enable,
    output logic [7:0]        fb_ram_in
);

    localparam int unsigned ROWS_D     = SRC_ROWS * SCALE;
    localparam int unsigned COLS_D     = SRC_BPR * SCALE;
    localparam int unsigned ROW_W      = (ROWS_D > 1) ? $clog2(ROWS_D) : 1;
    localparam int unsigned COL_W      = (COLS_D > 1) ? $clog2(COLS_D) : 1;
    localparam int unsigned SH         = (SCALE == 2) ? 1 : 0;
    // Drain covers the read latency, the capture and write stages, and one
    // quiet cycle before the completion pulse.
    localparam int unsigned DRAIN_LAST = RD_LAT + 2;
    localparam int unsigned DCNT_W     = $clog2(DRAIN_LAST + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [ROW_W-1:0]             r_row;
    logic [COL_W-1:0]             r_col;
    logic [DCNT_W-1:0]            r_dcnt;
    logic                         r_clear;
    logic                         w_issue;
    logic                         w_last;
    logic                         w_col_last;

    logic [RD_LAT-1:0]            r_pv;
    logic [RD_LAT-1:0]            r_pn;
    logic [RD_LAT-1:0][FB_AW-1:0] r_pa;

    logic                         r_cv;
    logic                         r_cn;
    logic [FB_AW-1:0]             r_ca;
    logic [7:0]                   r_cd;
    logic [3:0]                   w_nib;
    logic [7:0]                   w_wdata;

    assign w_issue    = (r_state == S_RUN);
    assign w_col_last = (r_col == COL_W'(COLS_D - 1));
    assign w_last     = w_col_last && (r_row == ROW_W'(ROWS_D - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_signal) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_dcnt == DCNT_W'(DRAIN_LAST)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Destination row/column walk, drain counter and latched mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row   <= '0;
            r_col   <= '0;
            r_dcnt  <= '0;
            r_clear <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_signal) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_clear <= clear_mode;
                    end
                end
                S_RUN: begin
                    r_dcnt <= '0;
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                S_DRAIN: r_dcnt <= r_dcnt + DCNT_W'(1);
                default: ;
            endcase
        end
    end

    // Read issue plus write-address/nibble delay line matching the RAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_ram_read_address <= '0;
            r_pv                  <= '0;
            r_pn                  <= '0;
            r_pa                  <= '0;
        end else begin
            if (w_issue) begin
                main_ram_read_address <= RAM_AW'(32'(SRC_BASE)
                                         + (32'(r_row) >> SH) * 32'(SRC_BPR)
                                         + (32'(r_col) >> SH));
            end
            r_pv[0] <= w_issue;
            r_pn[0] <= (SCALE == 2) && r_col[0];
            r_pa[0] <= FB_AW'(32'(r_row) * 32'(FB_PITCH) + 32'(r_col));
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pn[i] <= r_pn[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    // Capture read data alongside its delayed address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cv <= 1'b0;
            r_cn <= 1'b0;
            r_ca <= '0;
            r_cd <= '0;
        end else begin
            r_cv <= r_pv[RD_LAT-1];
            r_cn <= r_pn[RD_LAT-1];
            r_ca <= r_pa[RD_LAT-1];
            r_cd <= main_ram_out;
        end
    end

    // Pixel doubling / clear data path.
    always_comb begin
        w_nib   = r_cn ? r_cd[3:0] : r_cd[7:4];
        w_wdata = r_cd;
        if (SCALE == 2) begin
            w_wdata = {w_nib[3], w_nib[3], w_nib[2], w_nib[2],
                       w_nib[1], w_nib[1], w_nib[0], w_nib[0]};
        end
        if (r_clear) w_wdata = 8'h00;
    end

    // Registered framebuffer write port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_write_enable  <= 1'b0;
            fb_write_address <= '0;
            fb_ram_in        <= '0;
            busy             <= 1'b0;
            finished_signal  <= 1'b0;
        end else begin
            fb_write_enable  <= r_cv;
            fb_write_address <= r_ca;
            fb_ram_in        <= w_wdata;
            busy             <= (r_state == S_RUN) ||
                                ((r_state == S_DRAIN) && (w_next != S_DONE));
            finished_signal  <= (w_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_fb_scaler_copy.sv
// Testbench for fb_scaler_copy: a straight-copy instance (RD_LAT=2) and a
// pixel-doubling instance (SCALE=2, FB_PITCH=16, RD_LAT=1).
module tb_fb_scaler_copy;

    logic        clk;
    logic        reset;

    logic        a_start, a_clr, a_busy, a_fin, a_we;
    logic [11:0] a_rd;
    logic [7:0]  a_rdata, a_wdata, a_q;
    logic [9:0]  a_waddr;

    logic        b_start, b_clr, b_busy, b_fin, b_we;
    logic [11:0] b_rd;
    logic [7:0]  b_rdata, b_wdata;
    logic [9:0]  b_waddr;

    logic [7:0]  mem_a [0:4095];
    logic [7:0]  mem_b [0:4095];
    logic [7:0]  fb_a  [0:1023];
    logic [7:0]  fb_b  [0:1023];
    logic        fb_fill;

    int n_vec;
    int n_bad;

    fb_scaler_copy u_a (
        .clk(clk), .reset(reset), .start_signal(a_start), .clear_mode(a_clr),
        .busy(a_busy), .finished_signal(a_fin), .main_ram_read_address(a_rd),
        .main_ram_out(a_rdata), .fb_write_address(a_waddr),
        .fb_write_enable(a_we), .fb_ram_in(a_wdata)
    );

    fb_scaler_copy #(.SCALE(2), .FB_PITCH(16), .RD_LAT(1)) u_b (
        .clk(clk), .reset(reset), .start_signal(b_start), .clear_mode(b_clr),
        .busy(b_busy), .finished_signal(b_fin), .main_ram_read_address(b_rd),
        .main_ram_out(b_rdata), .fb_write_address(b_waddr),
        .fb_write_enable(b_we), .fb_ram_in(b_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main RAM models: two-edge latency for A, combinational for B.
    always @(posedge clk) a_q <= mem_a[a_rd];
    assign a_rdata = a_q;
    assign b_rdata = mem_b[b_rd];

    // Framebuffer RAM models with a bulk preload to 0xFF.
    always @(posedge clk) begin
        if (fb_fill) begin
            for (int i = 0; i < 1024; i++) begin
                fb_a[i] <= 8'hFF;
                fb_b[i] <= 8'hFF;
            end
        end else begin
            if (a_we) fb_a[a_waddr] <= a_wdata;
            if (b_we) fb_b[b_waddr] <= b_wdata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int inst, input bit st, input bit cl);
        if (inst == 0) begin a_start = st; a_clr = cl; end
        else           begin b_start = st; b_clr = cl; end
    endtask

    task automatic fill_mem(input int inst, input int mode);
        for (int i = 0; i < 4096; i++) begin
            logic [7:0] v;
            case (mode)
                0:       v = 8'(i);
                1:       v = 8'($urandom);
                default: v = (i == 'h100) ? 8'hA5 : 8'h00;
            endcase
            if (inst == 0) mem_a[i] = v;
            else           mem_b[i] = v;
        end
    endtask

    // Reference: destination byte at (r, c) derived from the source byte.
    function automatic int exp_data(input int inst, input bit clr, input int r, input int c);
        int s, src, b, nib, res;
        s   = (inst == 0) ? 1 : 2;
        src = 'h100 + (r / s) * 8 + c / s;
        b   = (inst == 0) ? int'(mem_a[src]) : int'(mem_b[src]);
        if (clr) return 0;
        if (s == 1) return b;
        nib = (c % 2 == 1) ? b % 16 : b / 16;
        res = 0;
        for (int i = 0; i < 4; i++)
            if (((nib >> i) & 1) == 1) res += 3 << (2 * i);
        return res;
    endfunction

    task automatic run_frame(input int inst, input bit clr, input int repulse,
                             input int exp_fin, input int extra, input bit preload);
        int s, cols, rows, pitch, rl, n, busy_bad, bad, first_bad;
        int w_edge[$], w_addr[$], w_data[$], fin_q[$];
        int efb[1024];
        logic we, bz, fn;
        int ad, dt;
        s     = (inst == 0) ? 1 : 2;
        cols  = 8 * s;
        rows  = 32 * s;
        pitch = (inst == 0) ? 32 : 16;
        rl    = (inst == 0) ? 2 : 1;
        n     = rows * cols;
        if (preload) begin
            fb_fill = 1'b1;
            @(posedge clk); #1;
            fb_fill = 1'b0;
        end
        for (int i = 0; i < 1024; i++) efb[i] = 'hFF;
        drive(inst, 1'b1, clr);
        @(posedge clk); #1;
        busy_bad = 0;
        for (int e = 1; e <= exp_fin + extra; e++) begin
            if (e == repulse) drive(inst, 1'b1, !clr);
            else              drive(inst, 1'b0, 1'($urandom));
            @(posedge clk); #1;
            if (inst == 0) begin
                we = a_we; ad = int'(a_waddr); dt = int'(a_wdata); bz = a_busy; fn = a_fin;
            end else begin
                we = b_we; ad = int'(b_waddr); dt = int'(b_wdata); bz = b_busy; fn = b_fin;
            end
            if (we) begin
                w_edge.push_back(e); w_addr.push_back(ad); w_data.push_back(dt);
            end
            if (fn) fin_q.push_back(e);
            if (bz != (e < exp_fin)) busy_bad++;
        end
        drive(inst, 1'b0, 1'b0);
        check("write_count", w_edge.size(), n);
        for (int k = 0; k < n && k < w_edge.size(); k++) begin
            int r, c, ea, ed;
            r  = k / cols;
            c  = k % cols;
            ea = (r * pitch + c) % 1024;
            ed = exp_data(inst, clr, r, c);
            efb[ea] = ed;
            check("write_edge", w_edge[k], k + 2 + rl);
            check("write_addr", w_addr[k], ea);
            check("write_data", w_data[k], ed);
        end
        check("finish_pulses", fin_q.size(), 1);
        if (fin_q.size() > 0) check("finish_edge", fin_q[0], exp_fin);
        check("busy_window_errors", busy_bad, 0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 1024; i++) begin
            int got;
            got = (inst == 0) ? int'(fb_a[i]) : int'(fb_b[i]);
            if (got != efb[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0) $display("first fb difference at address %0d", first_bad);
        check("fb_contents_bad_bytes", bad, 0);
    endtask

    typedef struct {
        int inst;
        bit clr;
        int fill;
        int repulse;
        int extra;
        int exp_fin;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   act, wc;

        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        fb_fill = 1'b0;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);

        tbl[0] = '{0, 1'b0, 0, -1,  6,  261};
        tbl[1] = '{0, 1'b0, 1, -1,  6,  261};
        tbl[2] = '{0, 1'b1, 1, -1,  6,  261};
        tbl[3] = '{0, 1'b0, 0, 50,  6,  261};
        tbl[4] = '{1, 1'b0, 2, -1,  6, 1028};
        tbl[5] = '{1, 1'b0, 1, -1,  6, 1028};
        tbl[6] = '{1, 1'b1, 1, -1,  6, 1028};
        tbl[7] = '{0, 1'b0, 1, 262, 8,  261};

        #2 reset = 1'b1;
        #1;
        act = {26'd0, a_busy, a_fin, a_we, |a_waddr, |a_wdata, |a_rd};
        check("reset_outputs_a", act, 0);
        act = {26'd0, b_busy, b_fin, b_we, |b_waddr, |b_wdata, |b_rd};
        check("reset_outputs_b", act, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            fill_mem(tbl[i].inst, tbl[i].fill);
            run_frame(tbl[i].inst, tbl[i].clr, tbl[i].repulse,
                      tbl[i].exp_fin, tbl[i].extra, 1'b1);
            if (tbl[i].inst == 1 && tbl[i].fill == 2) begin
                check("dbl_fb0",  int'(fb_b[0]),  'hCC);
                check("dbl_fb1",  int'(fb_b[1]),  'h33);
                check("dbl_fb16", int'(fb_b[16]), 'hCC);
                check("dbl_fb17", int'(fb_b[17]), 'h33);
                check("dbl_fb2",  int'(fb_b[2]),  'h00);
            end
            if (tbl[i].inst == 0 && tbl[i].clr) begin
                check("clr_unmapped_fb8", int'(fb_a[8]), 'hFF);
                check("clr_mapped_fb0",   int'(fb_a[0]), 'h00);
            end
        end

        // Back-to-back frames: second start in the first idle cycle after DONE.
        fill_mem(0, 1);
        run_frame(0, 1'b0, -1, 261, 1, 1'b1);
        run_frame(0, 1'b0, -1, 261, 6, 1'b0);

        // Reset in the middle of a frame, then a full frame afterwards.
        fill_mem(0, 0);
        drive(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0);
        for (int e = 1; e < 100; e++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_write_active", int'(a_we), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        act = {26'd0, a_busy, a_fin, a_we, |a_waddr, |a_wdata, |a_rd};
        check("async_reset_outputs", act, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        wc = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_we)   wc++;
            if (a_busy) wc++;
            if (a_fin)  wc++;
        end
        check("activity_after_reset", wc, 0);
        fill_mem(0, 1);
        run_frame(0, 1'b0, -1, 261, 6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
